// File: rtl/puf_crp_controller.sv
// Arbiter-PUF challenge/response collector: LFSR challenge generation, core sequencing, R-bit response capture.
// Optional PUF_MAJORITY_VOTE_EN: each challenge evaluated three times, response bit is the majority.
module puf_crp_controller #(
  parameter int unsigned    N          = 8,
  parameter int unsigned    R          = 16,
  parameter logic [N-1:0]   TAPS       = 'hB8,
  parameter int unsigned    SETTLE_CYC = 4,
  parameter int unsigned    EVAL_CYC   = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] seed,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [R-1:0] rsp_data,
  output logic [N-1:0] puf_challenge,
  output logic         puf_reset,
  output logic         puf_start,
  input  logic         puf_out,
  output logic         busy
);

  localparam int unsigned CMAX0 = (SETTLE_CYC > EVAL_CYC) ? SETTLE_CYC : EVAL_CYC;
  localparam int unsigned CMAX  = (CMAX0 > 2) ? CMAX0 : 2;
  localparam int unsigned CW    = $clog2(CMAX);
  localparam int unsigned BW    = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SETTLE,
    S_EVAL,
    S_SAMPLE,
    S_NEXT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    lfsr_q, lfsr_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [R-1:0]    data_q, data_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic            sync1_q, sync2_q;
  logic            init_q;
`ifdef PUF_MAJORITY_VOTE_EN
  logic [1:0]      rep_q, rep_d;
  logic [1:0]      vote_q, vote_d;
`endif

  // Right-shifting Galois step; TAPS is XORed in when the bit shifted out is 1.
  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      cyc_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      init_q  <= 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
      rep_q   <= '0;
      vote_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      cyc_q   <= cyc_d;
      sync1_q <= puf_out;
      sync2_q <= sync1_q;
      init_q  <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
      rep_q   <= rep_d;
      vote_q  <= vote_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    bit_d   = bit_q;
    data_d  = data_q;
    cyc_d   = cyc_q;
`ifdef PUF_MAJORITY_VOTE_EN
    rep_d   = rep_q;
    vote_d  = vote_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          lfsr_d  = (seed == '0) ? N'(1) : seed;
          bit_d   = '0;
          data_d  = '0;
          cyc_d   = '0;
`ifdef PUF_MAJORITY_VOTE_EN
          rep_d   = '0;
`endif
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        if (cyc_q == CW'(1)) begin
          cyc_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_SETTLE: begin
        if (cyc_q == CW'(SETTLE_CYC - 1)) begin
          cyc_d   = '0;
          state_d = S_EVAL;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_EVAL: begin
        if (cyc_q == CW'(EVAL_CYC - 1)) begin
          cyc_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_SAMPLE: begin
`ifdef PUF_MAJORITY_VOTE_EN
        // First two samples are parked; the third resolves the vote and commits the bit.
        if (rep_q == 2'd2) begin
          data_d[bit_q] = (vote_q[0] & vote_q[1]) | (vote_q[0] & sync2_q) |
                          (vote_q[1] & sync2_q);
          rep_d   = '0;
          state_d = S_NEXT;
        end else begin
          vote_d[rep_q[0]] = sync2_q;
          rep_d   = rep_q + 2'd1;
          state_d = S_CLR;
        end
`else
        data_d[bit_q] = sync2_q;
        state_d       = S_NEXT;
`endif
      end
      S_NEXT: begin
        lfsr_d = lfsr_step(lfsr_q);
        if (bit_q == BW'(R - 1)) begin
          state_d = S_DONE;
        end else begin
          bit_d   = bit_q + BW'(1);
          state_d = S_CLR;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign rsp_valid     = (state_q == S_DONE);
  assign rsp_data      = data_q;
  assign puf_challenge = lfsr_q;
  // init_q holds the core in clear from reset until the first clock edge.
  assign puf_reset     = init_q | (state_q == S_CLR);
  assign puf_start     = (state_q == S_EVAL) | (state_q == S_SAMPLE);

endmodule

// File: tb/tb_puf_crp_controller.sv
// Directed bench for puf_crp_controller: vector table of collections plus reset and DONE-stall sequences.
module tb_puf_crp_controller;

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int VOTE    = 1;
  localparam int EXP_CYC = 736;
`else
  localparam int VOTE    = 0;
  localparam int EXP_CYC = 256;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  seed;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [7:0]  puf_challenge;
  logic        puf_reset;
  logic        puf_start;
  logic        puf_out;
  logic        busy;

  puf_crp_controller #(.N(8), .R(16), .TAPS(8'hB8), .SETTLE_CYC(4), .EVAL_CYC(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .seed(seed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .puf_challenge(puf_challenge), .puf_reset(puf_reset), .puf_start(puf_start),
    .puf_out(puf_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // puf_out source: 0 const 0, 1 const 1, 2 challenge LSB, 3 pattern 1,0,1 over evaluations
  int         mode = 0;
  int         clr_cnt = 0;
  int         cur_idx = 0;
  int         chal_bad = 0;
  logic       prev_rst = 1'b0;
  logic [7:0] exp_chal [0:16];

  always_comb begin
    case (mode)
      0:       puf_out = 1'b0;
      1:       puf_out = 1'b1;
      2:       puf_out = puf_challenge[0];
      default: puf_out = (clr_cnt < 1) ? 1'b1 : (((clr_cnt - 1) % 3) != 1);
    endcase
  end

  always @(negedge clk) begin
    if (busy && puf_reset && !prev_rst) begin
      clr_cnt = clr_cnt + 1;
      cur_idx = VOTE ? (clr_cnt - 1) / 3 : clr_cnt - 1;
      if (cur_idx > 16 || puf_challenge !== exp_chal[cur_idx]) chal_bad = chal_bad + 1;
    end
    if (puf_start && (cur_idx > 16 || puf_challenge !== exp_chal[cur_idx])) chal_bad = chal_bad + 1;
    prev_rst = puf_reset;
  end

  function automatic logic [7:0] step(input logic [7:0] s);
    step = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic [7:0] s, input int m, input bit hold, input logic [15:0] exp_data);
    int          cyc;
    int          bad;
    logic [15:0] snap;
    exp_chal[0] = (s == 8'h00) ? 8'h01 : s;
    for (int i = 1; i < 17; i++) exp_chal[i] = step(exp_chal[i-1]);
    @(negedge clk);
    clr_cnt   = 0;
    cur_idx   = 0;
    chal_bad  = 0;
    mode      = m;
    seed      = s;
    rsp_ready = hold;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seed      = 8'h00;
    chk("busy_after_accept", {30'd0, busy, req_ready}, 32'd2);
    chk("first_challenge", {24'd0, puf_challenge}, {24'd0, exp_chal[0]});
    cyc = 0;
    while (!rsp_valid && cyc < 2000) begin
      req_valid = ((cyc % 37) == 5);
      @(posedge clk);
      cyc = cyc + 1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("latency", cyc, EXP_CYC);
    chk("rsp_data", {16'd0, rsp_data}, {16'd0, exp_data});
    chk("challenge_stable", chal_bad, 0);
    chk("eval_count", clr_cnt, VOTE ? 48 : 16);
    if (!hold) begin
      bad  = 0;
      snap = rsp_data;
      for (int i = 0; i < 20; i++) begin
        req_valid = ~req_valid;
        @(posedge clk);
        @(negedge clk);
        if (!rsp_valid || rsp_data !== snap || !busy || req_ready) bad = bad + 1;
      end
      req_valid = 1'b0;
      chk("done_stall_stable", bad, 0);
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {29'd0, rsp_valid, req_ready, busy}, 32'd2);
  endtask

  typedef struct {
    logic [7:0]  seed;
    int          mode;
    bit          hold;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{8'h01, 1, 1'b1, 16'hFFFF};
    vecs[1] = '{8'h01, 2, 1'b0, 16'hA471};
    vecs[2] = '{8'h00, 2, 1'b1, 16'hA471};
    vecs[3] = '{8'h80, 0, 1'b0, 16'h0000};
    vecs[4] = '{8'h01, 3, 1'b1, VOTE ? 16'hFFFF : 16'hDB6D};
    vecs[5] = '{8'h5A, 1, 1'b0, 16'hFFFF};

    reset     = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    seed      = 8'h00;
    #23;
    chk("reset_outputs", {22'd0, req_ready, rsp_valid, puf_challenge, puf_reset, puf_start},
        {22'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
    chk("reset_busy_data", {15'd0, busy, rsp_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("puf_reset_release", {31'd0, puf_reset}, 32'd0);

    for (int v = 0; v < 6; v++)
      run_req(vecs[v].seed, vecs[v].mode, vecs[v].hold, vecs[v].exp_data);

    // Reset 100 cycles into a collection, then a clean request must complete normally.
    @(negedge clk);
    mode      = 1;
    seed      = 8'h01;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrun_reset_outputs", {22'd0, req_ready, rsp_valid, puf_challenge, puf_reset, puf_start},
        {22'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
    chk("midrun_reset_busy_data", {15'd0, busy, rsp_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int stale;
      stale = 0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (rsp_valid || busy) stale = stale + 1;
      end
      chk("no_stale_rsp", stale, 0);
    end
    run_req(8'h01, 2, 1'b0, 16'hA471);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/puf_crp_controller.md
PUF_CRP_CONTROLLER -- requirements
Module: puf_crp_controller

Interface
REQ-001 SHALL have parameter N, default 8, challenge width driven to the arbiter core.
REQ-002 SHALL have parameter R, default 16, response bits collected per request.
REQ-003 SHALL have parameter TAPS, default 8'hB8, Galois LFSR feedback mask (width N).
REQ-004 SHALL have parameter SETTLE_CYC, default 4, cycles between core reset release and start.
REQ-005 SHALL have parameter EVAL_CYC, default 8, cycles start is held before sampling; EVAL_CYC >= 3.
REQ-006 SHALL have port clk  in  1  system clock, rising edge.
REQ-007 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port req_valid  in  1  request to run one R-bit collection.
REQ-009 SHALL have port req_ready  out  1  high only in IDLE.
REQ-010 SHALL have port seed  in  N  LFSR seed, captured on request acceptance.
REQ-011 SHALL have port rsp_valid  out  1  response word available.
REQ-012 SHALL have port rsp_ready  in  1  consumer accepts response.
REQ-013 SHALL have port rsp_data  out  R  collected response; bit k = response to k-th challenge.
REQ-014 SHALL have port puf_challenge  out  N  challenge to arbiter core.
REQ-015 SHALL have port puf_reset  out  1  core clear pulse (core acts on its rising edge).
REQ-016 SHALL have port puf_start  out  1  core launch (core acts on its rising edge).
REQ-017 SHALL have port puf_out  in  1  asynchronous core response.
REQ-018 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-019 SHALL synchronise puf_out through two flops before any use.
REQ-020 SHALL implement states IDLE, CLR, SETTLE, EVAL, SAMPLE, NEXT, DONE.
REQ-021 IDLE: req_ready=1; req_valid=1 at edge -> load LFSR with seed (0 replaced by 1), clear bit counter and rsp_data, go CLR.
REQ-022 CLR: puf_reset=1, puf_start=0, exactly 2 cycles -> SETTLE.
REQ-023 SETTLE: puf_reset=0, puf_start=0, exactly SETTLE_CYC cycles -> EVAL.
REQ-024 EVAL: puf_start=1, exactly EVAL_CYC cycles -> SAMPLE.
REQ-025 SAMPLE: 1 cycle, puf_start=1; synchronised puf_out written to rsp_data[bit counter].
REQ-026 NEXT: 1 cycle, puf_start=0; LFSR advances one step; if counter==R-1 -> DONE, else counter+1 -> CLR.
REQ-027 puf_challenge SHALL equal the LFSR state and be stable from CLR entry through SAMPLE.
REQ-028 Per-bit duration without voting SHALL be 2+SETTLE_CYC+EVAL_CYC+2 cycles (16 at defaults).
REQ-029 DONE: rsp_valid=1, rsp_data stable; rsp_ready=1 at edge -> IDLE; rsp_valid low the next cycle.
REQ-030 req_valid outside IDLE SHALL be ignored, not queued.
REQ-031 rsp_ready outside DONE SHALL be ignored.
REQ-032 Bit counter SHALL be ceil(log2(R)) bits and never wrap during one request.

Reset
REQ-033 reset SHALL force, asynchronously: state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, puf_challenge=0, puf_reset=1, puf_start=0, busy=0, counters=0, sync flops=0.
REQ-034 puf_reset SHALL drop to 0 on the first clk edge after reset deasserts.
REQ-035 reset mid-collection SHALL abandon the request; no partial rsp_valid is ever produced.

Configuration
REQ-036 Macro PUF_MAJORITY_VOTE_EN defined: each challenge evaluated 3 times (CLR..SAMPLE repeated, same challenge); rsp_data bit = majority of 3 samples; NEXT once per challenge; per-bit duration 3*(2+SETTLE_CYC+EVAL_CYC+1)+1 (46 at defaults).
REQ-037 Macro undefined: single evaluation per challenge, no vote logic or repeat counter present.

Verification
REQ-038 Default params, no macro, seed=8'h01, puf_out tied 1 -> rsp_valid at 256 cycles after acceptance, rsp_data=16'hFFFF.
REQ-039 puf_out model = puf_challenge[0] -> rsp_data bit k equals LSB of k-th LFSR state from seed 8'h01; challenge constant CLR..SAMPLE.
REQ-040 seed=0 -> first puf_challenge=8'h01, identical result to seed=8'h01.
REQ-041 Reset asserted at cycle 100 of collection -> outputs per REQ-033 immediately; new request completes normally with no stale rsp_valid.
REQ-042 rsp_ready held 0 for 20 cycles in DONE -> rsp_valid and rsp_data stable; req_valid pulses meanwhile ignored.
REQ-043 PUF_MAJORITY_VOTE_EN, puf_out pattern 1,0,1 per challenge -> every bit 1, rsp_valid at 736 cycles after acceptance.
